// File: rtl/pc_state_unit.sv
// pc_state_unit: program counter, instruction register, control state
// register and NZCV status register for the control datapath.
// Each non-stalled cycle applies the PC function, the IR/status load
// enables and the next control state from the control word.
// Optional build macro: PC_ALIGN_CHECK_EN
//   defined   - misaligned register-target loads hold PC and set the
//               sticky fault flag
//   undefined - register-target loads are word-aligned by clearing the
//               low two bits, and fault is tied low
module pc_state_unit #(
  parameter int unsigned    PCW      = 64,
  parameter int unsigned    KW       = 26,
  parameter logic [PCW-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            stall,
  input  logic [1:0]      PC_FS,
  input  logic [3:0]      NS,
  input  logic            IR_load,
  input  logic [31:0]     ir_in,
  input  logic            status_load,
  input  logic [3:0]      status_in,
  input  logic [PCW-1:0]  reg_in,
  input  logic [KW-1:0]   k,
  output logic [PCW-1:0]  PC,
  output logic [PCW-1:0]  PC_plus4,
  output logic [31:0]     IR,
  output logic [3:0]      state,
  output logic [3:0]      status,
  output logic            fault
);

  localparam logic [1:0] PC_HOLD = 2'b00;
  localparam logic [1:0] PC_INC  = 2'b01;
  localparam logic [1:0] PC_LOAD = 2'b10;
  localparam logic [1:0] PC_JUMP = 2'b11;

  localparam logic [PCW-1:0] WORD_BYTES = PCW'(4);
  localparam logic [PCW-1:0] LOW2_MASK  = PCW'(3);

  logic [PCW-1:0] pc_q, pc_d;
  logic [31:0]    ir_q, ir_d;
  logic [3:0]     state_q, state_d;
  logic [3:0]     status_q, status_d;

  logic [PCW-1:0] pc_inc;
  logic [PCW-1:0] jump_off;
  logic [PCW-1:0] jump_target;

  // Sequential successor and PC-relative target; k is a signed word
  // offset, so sign-extend to full width before scaling to bytes.
  assign pc_inc      = pc_q + WORD_BYTES;
  assign jump_off    = {{(PCW-KW){k[KW-1]}}, k} << 2;
  assign jump_target = pc_q + jump_off;

`ifdef PC_ALIGN_CHECK_EN
  logic fault_q, fault_d;
  logic load_misaligned;

  assign load_misaligned = (reg_in & LOW2_MASK) != '0;
`endif

  // Next-state selection for every register; stall freezes all of them.
  always_comb begin
    pc_d     = pc_q;
    ir_d     = ir_q;
    state_d  = state_q;
    status_d = status_q;
`ifdef PC_ALIGN_CHECK_EN
    fault_d  = fault_q;
`endif
    if (!stall) begin
      state_d = NS;
      if (IR_load)     ir_d     = ir_in;
      if (status_load) status_d = status_in;
      unique case (PC_FS)
        PC_HOLD: pc_d = pc_q;
        PC_INC:  pc_d = pc_inc;
        PC_LOAD: begin
`ifdef PC_ALIGN_CHECK_EN
          if (load_misaligned) begin
            fault_d = 1'b1;
          end else begin
            pc_d = reg_in;
          end
`else
          pc_d = reg_in & ~LOW2_MASK;
`endif
        end
        PC_JUMP: pc_d = jump_target;
        default: pc_d = pc_q;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      state_q  <= '0;
      status_q <= '0;
`ifdef PC_ALIGN_CHECK_EN
      fault_q  <= 1'b0;
`endif
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      state_q  <= state_d;
      status_q <= status_d;
`ifdef PC_ALIGN_CHECK_EN
      fault_q  <= fault_d;
`endif
    end
  end

  // Outputs; PC_plus4 is the combinational link value from the live PC.
  assign PC       = pc_q;
  assign PC_plus4 = pc_inc;
  assign IR       = ir_q;
  assign state    = state_q;
  assign status   = status_q;
`ifdef PC_ALIGN_CHECK_EN
  assign fault    = fault_q;
`else
  assign fault    = 1'b0;
`endif

endmodule

// File: tb/tb_pc_state_unit.sv
// Testbench for pc_state_unit: directed test-plan steps followed by a
// randomized run, all checked against a behavioural model of the rules.
module tb_pc_state_unit;

  localparam logic [63:0] RST_PC = 64'h40;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic [1:0]  PC_FS = 2'b00;
  logic [3:0]  NS = 4'h0;
  logic        IR_load = 1'b0;
  logic [31:0] ir_in = 32'h0;
  logic        status_load = 1'b0;
  logic [3:0]  status_in = 4'h0;
  logic [63:0] reg_in = 64'h0;
  logic [25:0] k = 26'h0;
  logic [63:0] PC, PC_plus4;
  logic [31:0] IR;
  logic [3:0]  state, status;
  logic        fault;

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  logic [63:0] m_pc;
  logic [31:0] m_ir;
  logic [3:0]  m_state, m_status;
  logic        m_fault;

  pc_state_unit #(.PCW(64), .KW(26), .RESET_PC(RST_PC)) dut (
    .clock(clock), .reset_n(reset_n), .stall(stall), .PC_FS(PC_FS), .NS(NS),
    .IR_load(IR_load), .ir_in(ir_in), .status_load(status_load),
    .status_in(status_in), .reg_in(reg_in), .k(k), .PC(PC),
    .PC_plus4(PC_plus4), .IR(IR), .state(state), .status(status), .fault(fault)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_ir = '0; m_state = '0; m_status = '0; m_fault = 1'b0;
  endtask

  // Apply the documented per-cycle rules to the model, using current inputs.
  task automatic model_step();
    longint off;
    if (stall) return;
    off = longint'($signed(k)) * 4;
    case (PC_FS)
      2'd1: m_pc = m_pc + 64'd4;
      2'd2: begin
`ifdef PC_ALIGN_CHECK_EN
        if (reg_in % 4 != 0) m_fault = 1'b1;
        else m_pc = reg_in;
`else
        m_pc = reg_in - (reg_in % 4);
`endif
      end
      2'd3: m_pc = m_pc + 64'(off);
      default: ;
    endcase
    if (IR_load) m_ir = ir_in;
    if (status_load) m_status = status_in;
    m_state = NS;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"}, PC, m_pc);
    check({tag, ".pc4"}, PC_plus4, m_pc + 64'd4);
    check({tag, ".ir"}, {32'h0, IR}, {32'h0, m_ir});
    check({tag, ".state"}, {60'h0, state}, {60'h0, m_state});
    check({tag, ".status"}, {60'h0, status}, {60'h0, m_status});
    check({tag, ".fault"}, {63'h0, fault}, {63'h0, m_fault});
  endtask

  // One clock: update model from pre-edge inputs, then sample after the edge.
  task automatic step(input string tag);
    model_step();
    @(posedge clock);
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    stall = 0; PC_FS = 0; NS = 0; IR_load = 0; status_load = 0;
  endtask

  task automatic load_pc(input logic [63:0] v);
    PC_FS = 2'd2; reg_in = v;
    step("load");
    idle_inputs();
  endtask

  initial begin
    model_reset();
    // Reset held over a couple of edges
    repeat (2) @(posedge clock);
    #1;
    check_all("rst");
    check("rst.pc_const", PC, 64'h40);
    check("rst.pc4_const", PC_plus4, 64'h44);
    reset_n = 1'b1;
    step("rst_rel");

    // Sequential fetch
    PC_FS = 2'd1;
    step("seq1"); check("seq1.c", PC, 64'h44);
    step("seq2"); check("seq2.c", PC, 64'h48);
    step("seq3"); check("seq3.c", PC, 64'h4C);
    load_pc(64'hFFFF_FFFF_FFFF_FFFC);
    PC_FS = 2'd1;
    step("wrap"); check("wrap.c", PC, 64'h0);

    // PC-relative jumps
    load_pc(64'h100);
    PC_FS = 2'd3; k = 26'h3FFFFFE;
    step("jmp_neg"); check("jmp_neg.c", PC, 64'hF8);
    load_pc(64'h100);
    PC_FS = 2'd3; k = 26'd5;
    step("jmp_pos"); check("jmp_pos.c", PC, 64'h114);
    idle_inputs();

    // Register-target load, misaligned then aligned
    load_pc(64'h2002);
`ifdef PC_ALIGN_CHECK_EN
    check("br.c", PC, 64'h114); check("br.fault", {63'h0, fault}, 64'h1);
`else
    check("br.c", PC, 64'h2000); check("br.fault", {63'h0, fault}, 64'h0);
`endif
    load_pc(64'h3000);
    check("br2.c", PC, 64'h3000);
`ifdef PC_ALIGN_CHECK_EN
    check("br2.fault", {63'h0, fault}, 64'h1);
`else
    check("br2.fault", {63'h0, fault}, 64'h0);
`endif

    // Stall for three cycles, then release with the same inputs applied
    stall = 1; PC_FS = 2'd1; IR_load = 1; NS = 4'd2; status_load = 1;
    ir_in = 32'hDEAD_BEEF; status_in = 4'hA;
    step("stall1"); step("stall2"); step("stall3");
    check("stall.pc", PC, 64'h3000);
    stall = 0;
    step("unstall");
    check("unstall.pc", PC, 64'h3004);
    check("unstall.ir", {32'h0, IR}, 64'hDEAD_BEEF);
    check("unstall.state", {60'h0, state}, 64'h2);
    check("unstall.status", {60'h0, status}, 64'hA);

    // Asynchronous reset in the middle of a branch
    IR_load = 0; status_load = 0; NS = 4'd2; PC_FS = 2'd3; k = 26'd3;
    step("br_seq");
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_all("arst");
    check("arst.pc_const", PC, 64'h40);
    @(posedge clock); #1;
    check_all("arst_hold");
    #2 reset_n = 1'b1;
    idle_inputs();

    // Randomized run against the model
    for (int i = 0; i < 400; i++) begin
      stall       = ($urandom_range(0, 3) == 0);
      PC_FS       = 2'($urandom_range(0, 3));
      NS          = 4'($urandom);
      IR_load     = 1'($urandom);
      ir_in       = $urandom;
      status_load = 1'($urandom);
      status_in   = 4'($urandom);
      reg_in      = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0) reg_in[1:0] = 2'b00;
      k           = 26'($urandom);
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
